ps2_keyboard_rx: RTL and testbench

//  PS/2 device-to-host receiver with a small scan-code FIFO.
//  - Oversamples ps2_clk/ps2_data in the system clock domain and deframes 11-bit PS/2 frames.
//  - Queues each valid 8-bit scan code (make codes, 0xF0 break prefix, 0xE0) for a consumer.
//  - Sits between the PS/2 pins and scan-code decode/note logic.

---
 rtl/ps2_keyboard_rx.sv | 137 +++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host receiver with a small scan-code FIFO.
//
// Oversamples the raw PS/2 clock in the system clock domain, deframes 11-bit
// frames (start, 8 data bits LSB-first, odd parity, stop) and queues each valid
// scan code. The FIFO holds 2**FIFO_AW - 1 codes; a valid frame arriving while
// it is full is dropped and sets the sticky overflow flag.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   - frames must also carry correct odd parity
//   undefined - parity bit ignored, only start/stop are checked
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   data       out  scan code at FIFO head, valid while ready=1
//   ready      out  FIFO non-empty
//   nextdata_n in   active-low pop request, level-sensitive
//   overflow   out  sticky: a valid frame was dropped because the FIFO was full
module ps2_keyboard_rx #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PtrOne = 1;

  logic [2:0]         sync_q, sync_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [9:0]         shift_q, shift_d;
  logic [FIFO_AW-1:0] wp_q, wp_d;
  logic [FIFO_AW-1:0] rp_q, rp_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;

  logic [7:0] fifo_mem [Depth];

  logic sample;
  logic frame_done;
  logic frame_ok;
  logic full;
  logic wr_en;
  logic pop;

  // Falling edge of the synchronised PS/2 clock.
  assign sample     = sync_q[2] & ~sync_q[1];
  assign frame_done = sample && (cnt_q == 4'd10);

  // At the 11th sample shift_q holds bits 0..9 (start at [0]); ps2_data is the stop bit.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = ~shift_q[0] & ps2_data & (^shift_q[9:1]);
`else
  assign frame_ok = ~shift_q[0] & ps2_data;
`endif

  // Full test uses pre-pop pointers, so a simultaneous pop does not make room.
  assign full  = ((wp_q + PtrOne) == rp_q);
  assign wr_en = frame_done & frame_ok & ~full;
  assign pop   = ready_q & ~nextdata_n;

  always_comb begin
    sync_d     = {sync_q[1:0], ps2_clk};
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    ready_d    = ready_q;
    overflow_d = overflow_q;

    if (sample) begin
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
      end else begin
        cnt_d   = cnt_q + 4'd1;
        shift_d = {ps2_data, shift_q[9:1]};
      end
    end

    if (frame_done && frame_ok && full) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rp_d = rp_q + PtrOne;
      if ((rp_q + PtrOne) == wp_q) begin
        ready_d = 1'b0;
      end
    end

    // A write overrides the empty indication of a same-cycle pop.
    if (wr_en) begin
      wp_d    = wp_q + PtrOne;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 3'b111;
      cnt_q      <= 4'd0;
      shift_q    <= 10'd0;
      wp_q       <= '0;
      rp_q       <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wp_q] <= shift_q[8:1];
    end
  end

  assign data     = fifo_mem[rp_q];
  assign ready    = ready_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed sequences, a vector table,
// and randomized frames/pops checked against a queue-based reference model.
module tb_ps2_keyboard_rx;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_keyboard_rx #(.FIFO_AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .ready      (ready),
    .nextdata_n (nextdata_n),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityChecked = 1'b1;
`else
  localparam bit ParityChecked = 1'b0;
`endif

  typedef struct {
    logic [7:0] code;
    logic       start;
    logic       par_good;
    logic       stop;
    logic       exp_ok;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic start,
                                             input logic par_good, input logic stop);
    logic par;
    par = par_good ? ~(^code) : (^code);
    return {stop, par, code, start};
  endfunction

  function automatic bit frame_valid(input logic [7:0] code, input logic start,
                                     input logic par_good, input logic stop);
    return (start == 1'b0) && (stop == 1'b1) && (par_good || !ParityChecked);
  endfunction

  // Sends the first nbits of a frame. With pop_at_stop, nextdata_n is pulsed
  // low for the clock edge on which the stop bit's write happens (third
  // rising edge after the pin falls on a falling clk edge).
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_stop) begin
        @(posedge clk);
        @(posedge clk);
        #1 nextdata_n = 1'b0;
        @(posedge clk);
        #1 nextdata_n = 1'b1;
      end
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_code(input logic [7:0] code);
    send_bits(make_frame(code, 1'b0, 1'b1, 1'b1), 11, 1'b0);
  endtask

  task automatic pop1();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t        vecs [6];
  logic [7:0]  model_q [$];
  bit          model_ovf;

  initial begin
    rst        = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;

    vecs[0] = '{code: 8'h1C, start: 1'b0, par_good: 1'b1, stop: 1'b1, exp_ok: 1'b1};
    vecs[1] = '{code: 8'h1C, start: 1'b0, par_good: 1'b0, stop: 1'b1, exp_ok: !ParityChecked};
    vecs[2] = '{code: 8'h55, start: 1'b1, par_good: 1'b1, stop: 1'b1, exp_ok: 1'b0};
    vecs[3] = '{code: 8'hAA, start: 1'b0, par_good: 1'b1, stop: 1'b0, exp_ok: 1'b0};
    vecs[4] = '{code: 8'hE0, start: 1'b0, par_good: 1'b1, stop: 1'b1, exp_ok: 1'b1};
    vecs[5] = '{code: 8'h77, start: 1'b0, par_good: 1'b0, stop: 1'b1, exp_ok: !ParityChecked};

    repeat (3) @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame then single-cycle pop.
    send_code(8'h1C);
    check("single_ready", ready, 1);
    check("single_data", data, 8'h1C);
    check("single_overflow", overflow, 0);
    pop1();
    check("single_pop_ready", ready, 0);

    // Break sequence ordering.
    send_code(8'hF0);
    send_code(8'h1C);
    check("brk_head", data, 8'hF0);
    pop1();
    check("brk_second", data, 8'h1C);
    check("brk_ready", ready, 1);
    pop1();
    check("brk_empty", ready, 0);

    // Fill past capacity.
    for (int i = 1; i <= 8; i++) send_code(i[7:0]);
    check("full_overflow", overflow, 1);
    check("full_ready", ready, 1);
    for (int i = 1; i <= 7; i++) begin
      check("full_drain_data", data, i);
      pop1();
    end
    check("full_drained", ready, 0);
    check("overflow_sticky", overflow, 1);
    do_reset();
    check("overflow_cleared", overflow, 0);

    // Table-driven framing checks.
    for (int v = 0; v < 6; v++) begin
      send_bits(make_frame(vecs[v].code, vecs[v].start, vecs[v].par_good, vecs[v].stop),
                11, 1'b0);
      check($sformatf("vec%0d_ready", v), ready, vecs[v].exp_ok);
      if (vecs[v].exp_ok) begin
        check($sformatf("vec%0d_data", v), data, vecs[v].code);
        pop1();
        check($sformatf("vec%0d_popped", v), ready, 0);
      end
    end

    // Reset mid-frame discards the partial frame.
    send_bits(make_frame(8'h5A, 1'b0, 1'b1, 1'b1), 5, 1'b0);
    do_reset();
    send_code(8'h23);
    check("partial_ready", ready, 1);
    check("partial_data", data, 8'h23);
    pop1();
    check("partial_empty", ready, 0);

    // Pop coinciding with a write.
    send_code(8'h11);
    send_bits(make_frame(8'h22, 1'b0, 1'b1, 1'b1), 11, 1'b1);
    check("same_clk_ready", ready, 1);
    check("same_clk_data", data, 8'h22);
    pop1();
    check("same_clk_empty", ready, 0);

    // Randomized frames and pops against a queue model.
    do_reset();
    model_q.delete();
    model_ovf = 1'b0;
    for (int it = 0; it < 40; it++) begin
      logic [7:0] code;
      logic       st, pg, sp;
      int         npop;
      code = 8'($urandom);
      st   = ($urandom_range(0, 7) == 0);
      pg   = ($urandom_range(0, 5) != 0);
      sp   = ($urandom_range(0, 7) != 0);
      send_bits(make_frame(code, st, pg, sp), 11, 1'b0);
      if (frame_valid(code, st, pg, sp)) begin
        if (model_q.size() < 7) model_q.push_back(code);
        else model_ovf = 1'b1;
      end
      check("rnd_ready", ready, model_q.size() != 0);
      check("rnd_overflow", overflow, model_ovf);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (model_q.size() != 0) begin
          check("rnd_data", data, model_q[0]);
          void'(model_q.pop_front());
        end
        pop1();
        check("rnd_pop_ready", ready, model_q.size() != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
